// File: rtl/cv32e40x_div_unrolled_if.sv
// ============================================================================
// Module      : cv32e40x_div_unrolled_if (with cv32e40x_div_unrolled_pkg)
// Description : Opcode type and request/response bundle for the unrolled divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40x_div_unrolled_pkg;
  // bit 0 = signed, bit 1 = remainder
  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_opcode_e;
endpackage

interface cv32e40x_div_unrolled_if #(
  parameter int WIDTH = 32
);
  import cv32e40x_div_unrolled_pkg::*;

  div_opcode_e      operator_i;
  logic             const_cycles_en_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             valid_i;
  logic             ready_o;
  logic             kill_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;

  modport master (
    output operator_i, const_cycles_en_i, op_a_i, op_b_i, valid_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  operator_i, const_cycles_en_i, op_a_i, op_b_i, valid_i, kill_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

`default_nettype wire

// File: rtl/cv32e40x_div_unrolled.sv
// ============================================================================
// Module      : cv32e40x_div_unrolled
// Description : Iterative DIV/DIVU/REM/REMU divider, UNROLL quotient bits per
//               cycle, magnitude-based early termination, kill and optional
//               result cache (macro CV32E40X_DIV_RESULT_CACHE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40x_div_unrolled
  import cv32e40x_div_unrolled_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  cv32e40x_div_unrolled_if.slave div_if
);

  localparam int CLZ_W = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(WIDTH / UNROLL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             is_signed_q, is_signed_d;
  logic             is_rem_q, is_rem_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

`ifdef CV32E40X_DIV_RESULT_CACHE_EN
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             cache_valid_q, cache_valid_d;
  logic             cache_signed_q, cache_signed_d;
  logic [WIDTH-1:0] cache_a_q, cache_a_d;
  logic [WIDTH-1:0] cache_b_q, cache_b_d;
  logic [WIDTH-1:0] cache_quot_q, cache_quot_d;
  logic [WIDTH-1:0] cache_rem_q, cache_rem_d;
  logic             cache_hit;
`endif

  logic             op_signed;
  logic             op_rem;
  logic             accept;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CLZ_W-1:0] lz_a;
  logic [CLZ_W-1:0] sig_bits;
  logic [CLZ_W-1:0] iters;
  logic [CLZ_W-1:0] shamt;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_sh;
  logic [WIDTH:0]   trial;
  logic             qbit;

  function automatic logic [CLZ_W-1:0] clz(input logic [WIDTH-1:0] v);
    clz = CLZ_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) clz = CLZ_W'(WIDTH - 1 - i);
    end
  endfunction

  function automatic logic [WIDTH-1:0] fix_quot(input logic [WIDTH-1:0] q, input logic sgn,
                                                input logic sa, input logic sb, input logic bz);
    if (bz)                    fix_quot = '1;
    else if (sgn && (sa != sb)) fix_quot = -q;
    else                        fix_quot = q;
  endfunction

  function automatic logic [WIDTH-1:0] fix_rem(input logic [WIDTH-1:0] r, input logic sgn,
                                               input logic sa);
    fix_rem = (sgn && sa) ? -r : r;
  endfunction

  // Operand preparation: magnitudes, leading-zero count and iteration count.
  always_comb begin
    op_signed = (div_if.operator_i == DIV_DIV) || (div_if.operator_i == DIV_REM);
    op_rem    = (div_if.operator_i == DIV_REMU) || (div_if.operator_i == DIV_REM);
    abs_a     = (op_signed && div_if.op_a_i[WIDTH-1]) ? -div_if.op_a_i : div_if.op_a_i;
    abs_b     = (op_signed && div_if.op_b_i[WIDTH-1]) ? -div_if.op_b_i : div_if.op_b_i;
    lz_a      = clz(abs_a);
    sig_bits  = CLZ_W'(WIDTH) - lz_a;
    if (div_if.const_cycles_en_i) begin
      iters = CLZ_W'(WIDTH / UNROLL);
    end else begin
      iters = (sig_bits + CLZ_W'(UNROLL - 1)) / CLZ_W'(UNROLL);
      if (iters == '0) iters = CLZ_W'(1);
    end
    // Align so exactly iters*UNROLL bits are consumed; the zero fill keeps
    // the upper quotient bits clear when iterations end early.
    shamt     = CLZ_W'(WIDTH) - iters * CLZ_W'(UNROLL);
  end

  assign accept = div_if.valid_i && (state_q == S_IDLE) && !div_if.kill_i;

`ifdef CV32E40X_DIV_RESULT_CACHE_EN
  assign cache_hit = cache_valid_q && !div_if.const_cycles_en_i &&
                     (div_if.op_a_i == cache_a_q) && (div_if.op_b_i == cache_b_q) &&
                     (op_signed == cache_signed_q);
`endif

  // Restoring shift-subtract, UNROLL steps per cycle.
  always_comb begin
    step_rem = rem_q;
    step_sh  = shreg_q;
    trial    = '0;
    qbit     = 1'b0;
    for (int k = 0; k < UNROLL; k++) begin
      trial = {step_rem, step_sh[WIDTH-1]};
      if (trial >= {1'b0, divisor_q}) begin
        step_rem = WIDTH'(trial - {1'b0, divisor_q});
        qbit     = 1'b1;
      end else begin
        step_rem = trial[WIDTH-1:0];
        qbit     = 1'b0;
      end
      step_sh = {step_sh[WIDTH-2:0], qbit};
    end
  end

  always_comb begin
    state_d     = state_q;
    is_signed_d = is_signed_q;
    is_rem_d    = is_rem_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    b_zero_d    = b_zero_q;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
    hit_d          = hit_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    cache_valid_d  = cache_valid_q;
    cache_signed_d = cache_signed_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_quot_d   = cache_quot_q;
    cache_rem_d    = cache_rem_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_signed_d = op_signed;
          is_rem_d    = op_rem;
          sign_a_d    = div_if.op_a_i[WIDTH-1];
          sign_b_d    = div_if.op_b_i[WIDTH-1];
          b_zero_d    = (div_if.op_b_i == '0);
          rem_d       = '0;
          shreg_d     = abs_a << shamt;
          divisor_d   = abs_b;
          cnt_d       = CNT_W'(iters - CLZ_W'(1));
          state_d     = S_DIVIDE;
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
          op_a_d = div_if.op_a_i;
          op_b_d = div_if.op_b_i;
          hit_d  = 1'b0;
          if (cache_hit) begin
            hit_d    = 1'b1;
            result_d = op_rem ? cache_rem_q : cache_quot_q;
            state_d  = S_FINISH;
          end
`endif
        end
      end

      S_DIVIDE: begin
        if (div_if.kill_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = step_rem;
          shreg_d = step_sh;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = is_rem_q ? fix_rem(step_rem, is_signed_q, sign_a_q)
                                : fix_quot(step_sh, is_signed_q, sign_a_q, sign_b_q, b_zero_q);
            state_d  = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        if (div_if.kill_i) begin
          state_d = S_IDLE;
        end else if (div_if.ready_i) begin
          state_d = S_IDLE;
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
          // A hit already matches the stored entry; shreg/rem are stale then.
          if (!hit_q) begin
            cache_valid_d  = 1'b1;
            cache_signed_d = is_signed_q;
            cache_a_d      = op_a_q;
            cache_b_d      = op_b_q;
            cache_quot_d   = fix_quot(shreg_q, is_signed_q, sign_a_q, sign_b_q, b_zero_q);
            cache_rem_d    = fix_rem(rem_q, is_signed_q, sign_a_q);
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_signed_q <= 1'b0;
      is_rem_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      rem_q       <= '0;
      shreg_q     <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
      hit_q          <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quot_q   <= '0;
      cache_rem_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_signed_q <= is_signed_d;
      is_rem_q    <= is_rem_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      b_zero_q    <= b_zero_d;
      rem_q       <= rem_d;
      shreg_q     <= shreg_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
      hit_q          <= hit_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      cache_valid_q  <= cache_valid_d;
      cache_signed_q <= cache_signed_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_quot_q   <= cache_quot_d;
      cache_rem_q    <= cache_rem_d;
`endif
    end
  end

  assign div_if.ready_o  = (state_q == S_IDLE);
  assign div_if.valid_o  = (state_q == S_FINISH);
  assign div_if.result_o = result_q;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_div_unrolled.sv
// ============================================================================
// Module      : tb_cv32e40x_div_unrolled
// Description : Scoreboard bench for the unrolled divider against a plain
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40x_div_unrolled;
  import cv32e40x_div_unrolled_pkg::*;

  localparam int WIDTH  = 32;
  localparam int UNROLL = 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               lat;
    int               acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv32e40x_div_unrolled_if #(.WIDTH(WIDTH)) div_if ();

  cv32e40x_div_unrolled #(.WIDTH(WIDTH), .UNROLL(UNROLL)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  exp_t exp_q[$];
  exp_t cur;
  bit   in_flight = 1'b0;
  bit   bp_force  = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   cyc       = 0;

`ifdef CV32E40X_DIV_RESULT_CACHE_EN
  bit               m_cv = 1'b0;
  bit               m_cs = 1'b0;
  logic [WIDTH-1:0] m_ca = '0;
  logic [WIDTH-1:0] m_cb = '0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_signed_op(input div_opcode_e op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic [WIDTH-1:0] ref_result(input div_opcode_e op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    longint x, y, q, r;
    bit want_rem;
    want_rem = (op == DIV_REM) || (op == DIV_REMU);
    if (is_signed_op(op)) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = 0; x[WIDTH-1:0] = a;
      y = 0; y[WIDTH-1:0] = b;
    end
    if (y == 0) begin
      q = -1;
      r = x;
    end else begin
      q = x / y;
      r = x % y;
    end
    return want_rem ? WIDTH'(r) : WIDTH'(q);
  endfunction

  function automatic int ref_latency(input div_opcode_e op, input logic cst,
                                     input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] mag;
    int nbits, n;
    mag   = (is_signed_op(op) && a[WIDTH-1]) ? -a : a;
    nbits = 0;
    for (int i = 0; i < WIDTH; i++) if (mag[i]) nbits = i + 1;
    if (cst) n = WIDTH / UNROLL;
    else     n = (nbits + UNROLL - 1) / UNROLL;
    if (n < 1) n = 1;
    return n + 1;
  endfunction

  task automatic issue(input div_opcode_e op, input logic cst,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit completes);
    int   guard;
    bit   hit;
    exp_t e;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!div_if.ready_o && guard < 200);
    if (!div_if.ready_o) check("ready_wait", {63'd0, div_if.ready_o}, 64'd1);
    div_if.operator_i        = op;
    div_if.const_cycles_en_i = cst;
    div_if.op_a_i            = a;
    div_if.op_b_i            = b;
    div_if.valid_i           = 1'b1;
    hit = 1'b0;
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
    hit = m_cv && !cst && (a == m_ca) && (b == m_cb) && (is_signed_op(op) == m_cs);
    if (completes && !hit) begin
      m_cv = 1'b1; m_ca = a; m_cb = b; m_cs = is_signed_op(op);
    end
`endif
    if (completes) begin
      e.res = ref_result(op, a, b);
      e.lat = hit ? 1 : ref_latency(op, cst, a);
      e.acc = cyc;
      e.a   = a;
      e.b   = b;
      exp_q.push_back(e);
    end
    @(negedge clk);
    div_if.valid_i    = 1'b0;
    div_if.op_a_i     = WIDTH'($urandom);
    div_if.op_b_i     = WIDTH'($urandom);
    div_if.operator_i = div_opcode_e'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || in_flight || !div_if.ready_o) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain", {32'd0, exp_q.size()}, 64'd0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom) >> $urandom_range(0, WIDTH - 1);
    endcase
  endfunction

  // Consumer back-pressure, changed just after the active edge.
  initial begin
    div_if.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      div_if.ready_i = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each new result and checks it while held.
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
    end else if (div_if.valid_o) begin
      if (!in_flight) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {63'd0, div_if.valid_o}, 64'd0);
        end else begin
          cur       = exp_q.pop_front();
          in_flight = 1'b1;
          check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          check("result", 64'(div_if.result_o), 64'(cur.res));
        end
      end else begin
        check("held_result", 64'(div_if.result_o), 64'(cur.res));
      end
      if (div_if.ready_i) in_flight = 1'b0;
    end else if (in_flight) begin
      check("valid_dropped", {63'd0, div_if.valid_o}, 64'd1);
      in_flight = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    div_opcode_e      op;
    logic             cst;
    int               guard;

    div_if.operator_i        = DIV_DIVU;
    div_if.const_cycles_en_i = 1'b0;
    div_if.op_a_i            = '0;
    div_if.op_b_i            = '0;
    div_if.valid_i           = 1'b0;
    div_if.kill_i            = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, div_if.ready_o}, 64'd1);
    check("rst_valid", {63'd0, div_if.valid_o}, 64'd0);
    check("rst_result", 64'(div_if.result_o), 64'd0);
    rst = 1'b0;

    issue(DIV_DIVU, 1'b0, 100, 7, 1'b1);
    issue(DIV_REMU, 1'b0, 100, 7, 1'b1);
    issue(DIV_DIV,  1'b1, -100, 7, 1'b1);
    issue(DIV_REM,  1'b1, -100, 7, 1'b1);
    issue(DIV_DIV,  1'b0, 32'h8000_0000, 0, 1'b1);
    issue(DIV_REM,  1'b0, 32'h8000_0000, 0, 1'b1);
    issue(DIV_DIVU, 1'b0, 5, 0, 1'b1);
    issue(DIV_DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(DIV_REM,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(DIV_DIV,  1'b0, 1000, -3, 1'b1);
    issue(DIV_REM,  1'b0, 1000, -3, 1'b1);
    issue(DIV_REM,  1'b0, 1000, -7, 1'b1);
    wait_idle();

    // Hold the result under back-pressure for five cycles.
    bp_force = 1'b1;
    issue(DIV_DIVU, 1'b0, 12345, 67, 1'b1);
    guard = 0;
    while (!div_if.valid_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("bp_valid_seen", {63'd0, div_if.valid_o}, 64'd1);
    repeat (5) @(negedge clk);
    check("bp_valid_held", {63'd0, div_if.valid_o}, 64'd1);
    bp_force = 1'b0;
    wait_idle();

    // Kill in the third DIVIDE cycle.
    issue(DIV_DIVU, 1'b1, 32'hFFFF_FFFF, 3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    div_if.kill_i = 1'b1;
    @(negedge clk);
    div_if.kill_i = 1'b0;
    check("kill_ready", {63'd0, div_if.ready_o}, 64'd1);
    check("kill_valid", {63'd0, div_if.valid_o}, 64'd0);
    issue(DIV_DIVU, 1'b0, 9, 3, 1'b1);
    wait_idle();

    // Kill in IDLE wins over a simultaneous request.
    div_if.operator_i = DIV_DIVU;
    div_if.op_a_i     = 50;
    div_if.op_b_i     = 5;
    div_if.valid_i    = 1'b1;
    div_if.kill_i     = 1'b1;
    @(negedge clk);
    div_if.valid_i = 1'b0;
    div_if.kill_i  = 1'b0;
    check("idle_kill_ready", {63'd0, div_if.ready_o}, 64'd1);
    repeat (3) @(negedge clk);

    // Reset in the middle of DIVIDE.
    issue(DIV_DIV, 1'b1, -100, 7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {63'd0, div_if.ready_o}, 64'd1);
    check("midrst_valid", {63'd0, div_if.valid_o}, 64'd0);
    check("midrst_result", 64'(div_if.result_o), 64'd0);
`ifdef CV32E40X_DIV_RESULT_CACHE_EN
    m_cv = 1'b0;
`endif
    issue(DIV_REM, 1'b0, 1000, -7, 1'b1);
    wait_idle();

    for (int n = 0; n < 250; n++) begin
      op  = div_opcode_e'($urandom_range(0, 3));
      cst = ($urandom_range(0, 3) == 0);
      if (n == 0 || $urandom_range(0, 4) != 0) begin
        a = rnd_operand();
        b = rnd_operand();
      end
      issue(op, cst, a, b, 1'b1);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
